conv_window_ctrl: RTL and testbench

CONV_WINDOW_CTRL -- requirements
Module: conv_window_ctrl

---
 rtl/conv_pkg.sv | 17 +
 rtl/raster_counter.sv | 46 ++++
 rtl/conv_window_ctrl.sv | 138 +++++++++++++
 tb/tb_conv_window_ctrl.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/conv_pkg.sv
// Shared types and default geometry for the convolution window controller.
// No logic; imported by conv_window_ctrl and raster_counter.
// Backpressure: n/a.
package conv_pkg;

    localparam int unsigned DEF_LINE_LENGTH = 28;
    localparam int unsigned DEF_NUM_LINES   = 28;
    localparam int unsigned DEF_WINDOW_SIZE = 3;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_FLUSH,
        ST_DONE
    } state_t;

endpackage

// File: rtl/raster_counter.sv
// Row/column tracker for a raster-scanned frame; last flags the final pixel.
// Latency: position updates the cycle after advance.
// Backpressure: none; advance is only asserted by the owner when a pixel is taken.
module raster_counter
    import conv_pkg::*;
#(
    parameter int LINE_LENGTH = DEF_LINE_LENGTH,
    parameter int NUM_LINES   = DEF_NUM_LINES,
    localparam int CW = $clog2(LINE_LENGTH),
    localparam int RW = $clog2(NUM_LINES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          clear,
    input  logic          advance,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic col_last;
    logic row_last;

    assign col_last = (col == CW'(LINE_LENGTH - 1));
    assign row_last = (row == RW'(NUM_LINES - 1));
    assign last     = col_last && row_last;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col_last) begin
                col <= '0;
                // Wrap the row too so the counter never leaves the frame.
                row <= row_last ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/conv_window_ctrl.sv
// Sequences a sliding-window buffer over one frame; optional stride-2 via CONV_WINDOW_CTRL_STRIDE_EN.
// Latency: window_valid_o rises the cycle after the window's bottom-right pixel is accepted.
// Backpressure: an unconsumed window blocks in_ready_o until out_ready_i; FLUSH accepts nothing.
module conv_window_ctrl
    import conv_pkg::*;
#(
    parameter int LINE_LENGTH = DEF_LINE_LENGTH,
    parameter int NUM_LINES   = DEF_NUM_LINES,
    parameter int WINDOW_SIZE = DEF_WINDOW_SIZE,
    localparam int CW = $clog2(LINE_LENGTH),
    localparam int RW = $clog2(NUM_LINES)
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          start_i,
`ifdef CONV_WINDOW_CTRL_STRIDE_EN
    input  logic          stride_i,
`endif
    input  logic          in_valid_i,
    output logic          in_ready_o,
    output logic          buf_enable_o,
    input  logic          out_ready_i,
    output logic          window_valid_o,
    output logic [RW-1:0] win_row_o,
    output logic [CW-1:0] win_col_o,
    output logic          busy_o,
    output logic          frame_done_o
);

    localparam logic [RW-1:0] ROW_OFF = RW'(WINDOW_SIZE - 1);
    localparam logic [CW-1:0] COL_OFF = CW'(WINDOW_SIZE - 1);

    state_t        state_q;
    state_t        state_d;
    logic          clear_cnt;
    logic          accept;
    logic          qualify;
    logic          stride_ok;
    logic          last_pix;
    logic [RW-1:0] row;
    logic [CW-1:0] col;
    logic [RW-1:0] row_rel;
    logic [CW-1:0] col_rel;

    raster_counter #(
        .LINE_LENGTH (LINE_LENGTH),
        .NUM_LINES   (NUM_LINES)
    ) u_raster (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .clear   (clear_cnt),
        .advance (accept),
        .row     (row),
        .col     (col),
        .last    (last_pix)
    );

    assign in_ready_o   = (state_q == ST_RUN) && (!window_valid_o || out_ready_i);
    assign accept       = in_valid_i && in_ready_o;
    assign buf_enable_o = accept;

    assign row_rel = row - ROW_OFF;
    assign col_rel = col - COL_OFF;

`ifdef CONV_WINDOW_CTRL_STRIDE_EN
    logic stride_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            stride_q <= 1'b0;
        end else if (state_q == ST_IDLE && start_i) begin
            stride_q <= stride_i;
        end
    end

    assign stride_ok = !stride_q || (!row_rel[0] && !col_rel[0]);
`else
    assign stride_ok = 1'b1;
`endif

    assign qualify = (row >= ROW_OFF) && (col >= COL_OFF) && stride_ok;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        clear_cnt    = 1'b0;
        busy_o       = (state_q != ST_IDLE);
        frame_done_o = (state_q == ST_DONE);
        case (state_q)
            ST_IDLE: begin
                if (start_i) begin
                    state_d   = ST_RUN;
                    clear_cnt = 1'b1;
                end
            end
            ST_RUN: begin
                // A non-qualifying final pixel leaves nothing to drain: any
                // pending window was consumed in the same cycle it was taken.
                if (accept && last_pix) begin
                    state_d = qualify ? ST_FLUSH : ST_DONE;
                end
            end
            ST_FLUSH: begin
                if (window_valid_o && out_ready_i) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            window_valid_o <= 1'b0;
            win_row_o      <= '0;
            win_col_o      <= '0;
        end else if (accept && qualify) begin
            window_valid_o <= 1'b1;
            win_row_o      <= row_rel;
            win_col_o      <= col_rel;
        end else if (out_ready_i) begin
            window_valid_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_conv_window_ctrl.sv
// Randomized frame-level bench for conv_window_ctrl at default geometry with a window scoreboard.
module tb_conv_window_ctrl;

    localparam int LL     = 28;
    localparam int NL     = 28;
    localparam int WS     = 3;
    localparam int NPIX   = LL * NL;
    localparam int NWIN   = (NL - WS + 1) * (LL - WS + 1);
    localparam int BUDGET = 20000;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       stride = 1'b0;
    logic       in_valid = 1'b0;
    logic       out_ready = 1'b0;
    logic       in_ready_o;
    logic       buf_enable_o;
    logic       window_valid_o;
    logic [4:0] win_row_o;
    logic [4:0] win_col_o;
    logic       busy_o;
    logic       frame_done_o;

    int nchecks = 0;
    int nfails  = 0;

    always #5 clk = ~clk;

    conv_window_ctrl dut (
        .clk_i          (clk),
        .rst_ni         (rst_n),
        .start_i        (start),
`ifdef CONV_WINDOW_CTRL_STRIDE_EN
        .stride_i       (stride),
`endif
        .in_valid_i     (in_valid),
        .in_ready_o     (in_ready_o),
        .buf_enable_o   (buf_enable_o),
        .out_ready_i    (out_ready),
        .window_valid_o (window_valid_o),
        .win_row_o      (win_row_o),
        .win_col_o      (win_col_o),
        .busy_o         (busy_o),
        .frame_done_o   (frame_done_o)
    );

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        nchecks++;
        assert (obs === exp) else begin
            nfails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_wvld"}, window_valid_o, 0);
        chk({tag, "_row"}, win_row_o, 0);
        chk({tag, "_col"}, win_col_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
        chk({tag, "_done"}, frame_done_o, 0);
        chk({tag, "_in_rdy"}, in_ready_o, 0);
        chk({tag, "_buf_en"}, buf_enable_o, 0);
    endtask

    task automatic idle_ignore(input int ncyc);
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk); #1;
            in_valid  = 1'b1;
            out_ready = 1'(i[0]);
            @(negedge clk);
            chk("idle_buf_en", buf_enable_o, 0);
            chk("idle_busy", busy_o, 0);
        end
    endtask

    // Runs one frame; stop_at > 0 returns early (at a negedge) once that many pixels are accepted.
    task automatic run_frame(input int pv, input int pr, input int stop_at, input bit rnd_start);
        int exp_r[$];
        int exp_c[$];
        int acc = 0;
        int cons = 0;
        int cyc = 0;
        int last_cons = -10;
        int er;
        int ec;
        int prev_r = 0;
        int prev_c = 0;
        bit first = 1'b0;
        bit prev_stall = 1'b0;
        bit done = 1'b0;
        bit got_done = 1'b0;

        for (int r = 0; r <= NL - WS; r++)
            for (int c = 0; c <= LL - WS; c++) begin
                exp_r.push_back(r);
                exp_c.push_back(c);
            end

        @(posedge clk); #1;
        start = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("busy_after_start", busy_o, 1);

        while (!done && cyc < BUDGET) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 99) < pv);
            out_ready = ($urandom_range(0, 99) < pr);
            if (rnd_start) start = ($urandom_range(0, 3) == 0);
            cyc++;
            @(negedge clk);
            chk("buf_enable_rule", buf_enable_o, in_valid && in_ready_o);
            if (prev_stall) begin
                chk("stall_hold_vld", window_valid_o, 1);
                chk("stall_hold_row", win_row_o, prev_r);
                chk("stall_hold_col", win_col_o, prev_c);
            end
            if (window_valid_o && !out_ready) chk("stall_in_ready", in_ready_o, 0);
            if (window_valid_o && !first) begin
                first = 1'b1;
                chk("first_window_pixels", acc, 59);
                chk("first_window_row", win_row_o, 0);
                chk("first_window_col", win_col_o, 0);
            end
            if (acc == NPIX) chk("flush_in_ready", in_ready_o, 0);
            if (frame_done_o) begin
                chk("done_window_count", cons, NWIN);
                chk("done_timing", cyc, last_cons + 1);
                chk("done_pixel_count", acc, NPIX);
                chk("done_busy", busy_o, 1);
                done = 1'b1;
                got_done = 1'b1;
            end
            if (window_valid_o && out_ready) begin
                er = (exp_r.size() > 0) ? exp_r.pop_front() : -1;
                ec = (exp_c.size() > 0) ? exp_c.pop_front() : -1;
                chk("win_row", win_row_o, er);
                chk("win_col", win_col_o, ec);
                cons++;
                last_cons = cyc;
            end
            prev_stall = window_valid_o && !out_ready;
            prev_r = win_row_o;
            prev_c = win_col_o;
            if (buf_enable_o) acc++;
            if (stop_at > 0 && acc >= stop_at) done = 1'b1;
        end
        start = 1'b0;
        chk("frame_within_budget", done, 1);
        if (got_done) begin
            @(negedge clk);
            chk("after_done_busy", busy_o, 0);
            chk("after_done_pulse", frame_done_o, 0);
        end
    endtask

    initial begin
        #2;
        chk_reset_outputs("reset");
        #20;
        @(negedge clk);
        rst_n = 1'b1;
        idle_ignore(4);

        run_frame(100, 100, 0, 1'b0);
        run_frame(50, 50, 0, 1'b1);

        // Abandon a frame mid-way with reset asserted between clock edges.
        run_frame(100, 100, 300, 1'b0);
        in_valid = 1'b1;
        out_ready = 1'b0;
        #1;
        chk("pre_reset_busy", busy_o, 1);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("midframe_reset");
        @(negedge clk);
        rst_n = 1'b1;
        idle_ignore(5);

        run_frame(50, 50, 0, 1'b0);
        run_frame(90, 20, 0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", nchecks, nfails);
        $finish;
    end

endmodule
